// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM and its ALU decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEMADR   = 4'd3;
  localparam state_t S_MEMREAD  = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_MEMWRITE = 4'd6;
  localparam state_t S_EXECR    = 4'd7;
  localparam state_t S_EXECI    = 4'd8;
  localparam state_t S_ALUWB    = 4'd9;
  localparam state_t S_BEQ      = 4'd10;
  localparam state_t S_JAL      = 4'd11;
  localparam state_t S_JALR_ADR = 4'd12;
  localparam state_t S_TRAP     = 4'd13;

  // RV32I opcodes handled by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // What the FSM asks of the ALU; FUNCT defers to the instruction fields
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Datapath mux selects
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Immediate format implied by the opcode; I-format is the catch-all
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the control FSM (master) and the datapath it steers (slave).
// Latency: n/a (wires only).
// Backpressure: mem_ready from the memory side stalls mem_req holders.
interface multicycle_ctrl_if;
  // instruction fields and datapath status
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  // control strobes and selects
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;

  modport master (
    input  op, funct3, funct7_5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
  );

  modport slave (
    output op, funct3, funct7_5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
  );
endinterface

// File: rtl/alu_dec.sv
// ALU decoder: turns the FSM's alu_op plus instruction fields into the 3-bit ALU code.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module alu_dec
  import ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // sub only for R-type with funct7[5]; addi never becomes a subtract
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core; JALR support via MULTICYCLE_JALR_EN.
// Latency: 3-5 cycles per instruction with mem_ready tied high.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold mem_req and selects until mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  alu_op_e    alu_op;
  logic       pc_update;
  logic       branch;
  logic       taken;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_control;

  // next state and per-state datapath controls; anything not set stays 0
  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_OP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // precompute branch/jal target into ALUOut
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = (bus.funct3[2:1] == 2'b00) ? S_BEQ : S_TRAP;
          OP_JAL:            state_d = S_JAL;
`ifdef MULTICYCLE_JALR_EN
          OP_JALR:           state_d = S_JALR_ADR;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link address
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
`ifdef MULTICYCLE_JALR_EN
      S_JALR_ADR: begin
        // overwrite ALUOut with rs1+imm, then reuse the JAL sequence
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JAL;
      end
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // state register; reset drops all strobes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7_5    (bus.funct7_5),
    .alu_control (alu_control)
  );

  // beq takes on zero, bne on not-zero
  assign taken = bus.zero ^ bus.funct3[0];

  assign bus.mem_req     = mem_req;
  assign bus.mem_write   = mem_write;
  assign bus.adr_src     = adr_src;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_update | (branch & taken);
  assign bus.reg_write   = reg_write;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.result_src  = result_src;
  assign bus.imm_src     = (state_q == S_IDLE) ? IMM_I : imm_src_of(bus.op);
  assign bus.alu_control = alu_control;
  // TRAP never exits except through reset, so this is sticky
  assign bus.illegal     = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src,
            bus.imm_src, bus.alu_control, bus.illegal};
  endfunction

  function automatic logic [17:0] ex(input logic req, wr, adr, irw, pcw, rgw,
                                     input logic [1:0] a, b, res, imm,
                                     input logic [2:0] aluc, input logic ill);
    return {req, wr, adr, irw, pcw, rgw, a, b, res, imm, aluc, ill};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp_v);
    logic [17:0] obs;
    obs = outs();
    n_tests++;
    assert (obs === exp_v)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b (req wr adr irw pcw rgw a b res imm aluc ill)",
               tag, obs, exp_v);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("rst_assert_idle", 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_idle", 18'd0);
  endtask

  // fetch, decode, execute, writeback for an R/I-type ALU instruction
  task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] exp_aluc);
    bus.op = o; bus.funct3 = f3; bus.funct7_5 = f7; bus.mem_ready = 1'b1;
    tick(); chk({tag, "_fetch"},  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000,0));
    tick(); chk({tag, "_decode"}, ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000,0));
    tick(); chk({tag, "_exec"},   ex(0,0,0,0,0,0, 2'b10, (o[5] ? 2'b00 : 2'b01), 2'b00,2'b00, exp_aluc,0));
    tick(); chk({tag, "_aluwb"},  ex(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #2 chk("reset_idle", 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle_after_release", 18'd0);

    // ALU instructions
    alu_instr("r_add",  7'b0110011, 3'b000, 1'b0, 3'b000);
    alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
    alu_instr("r_slt",  7'b0110011, 3'b010, 1'b0, 3'b101);
    alu_instr("r_f011", 7'b0110011, 3'b011, 1'b0, 3'b000);
    alu_instr("i_addi", 7'b0010011, 3'b000, 1'b1, 3'b000);
    alu_instr("i_ori",  7'b0010011, 3'b110, 1'b0, 3'b011);
    alu_instr("i_andi", 7'b0010011, 3'b111, 1'b0, 3'b010);

    // load with two stall cycles in MEMREAD
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0; bus.mem_ready = 1'b1;
    tick(); chk("ld_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000,0));
    tick(); chk("ld_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000,0));
    bus.mem_ready = 1'b0;
    tick(); chk("ld_memadr", ex(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000,0));
    tick(); chk("ld_rd_w1",  ex(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
    tick(); chk("ld_rd_w2",  ex(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
    tick(); chk("ld_rd_w3",  ex(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
    bus.mem_ready = 1'b1;
    #1 chk("ld_rd_rdy",      ex(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
    tick(); chk("ld_memwb",  ex(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000,0));

    // store with a stalled fetch
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.mem_ready = 1'b0;
    tick(); chk("st_fetch_w1", ex(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b01, 3'b000,0));
    tick(); chk("st_fetch_w2", ex(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b01, 3'b000,0));
    bus.mem_ready = 1'b1;
    #1 chk("st_fetch_rdy",     ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b01, 3'b000,0));
    tick(); chk("st_decode",   ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b01, 3'b000,0));
    tick(); chk("st_memadr",   ex(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000,0));
    tick(); chk("st_memwrite", ex(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000,0));

    // beq, zero=1 -> taken
    bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.zero = 1'b1;
    tick(); chk("beq_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b10, 3'b000,0));
    tick(); chk("beq_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000,0));
    tick(); chk("beq_taken",  ex(0,0,0,0,1,0, 2'b10,2'b00,2'b00,2'b10, 3'b001,0));
    bus.zero = 1'b0;
    #1 chk("beq_nottaken",    ex(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001,0));

    // bne, zero=1 -> not taken
    bus.funct3 = 3'b001; bus.zero = 1'b1;
    tick(); chk("bne_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b10, 3'b000,0));
    tick(); chk("bne_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000,0));
    tick(); chk("bne_nottaken", ex(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001,0));
    bus.zero = 1'b0;
    #1 chk("bne_taken",       ex(0,0,0,0,1,0, 2'b10,2'b00,2'b00,2'b10, 3'b001,0));

    // jal
    bus.op = 7'b1101111; bus.funct3 = 3'b000;
    tick(); chk("jal_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b11, 3'b000,0));
    tick(); chk("jal_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b11, 3'b000,0));
    tick(); chk("jal_jal",    ex(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b11, 3'b000,0));
    tick(); chk("jal_aluwb",  ex(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 3'b000,0));

    // jalr
    bus.op = 7'b1100111;
    tick(); chk("jalr_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000,0));
    tick(); chk("jalr_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000,0));
`ifdef MULTICYCLE_JALR_EN
    tick(); chk("jalr_adr",    ex(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000,0));
    tick(); chk("jalr_jal",    ex(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 3'b000,0));
    tick(); chk("jalr_aluwb",  ex(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,0));
`else
    tick(); chk("jalr_trap",   ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,1));
    do_reset();
`endif

    // illegal opcode, sticky trap
    bus.op = 7'b1111111;
    tick(); chk("ill_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000,0));
    tick(); chk("ill_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000,0));
    tick(); chk("ill_trap",   ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,1));
    bus.op = 7'b0110011; bus.mem_ready = 1'b0; bus.zero = 1'b1;
    tick(); chk("ill_sticky1", ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,1));
    bus.mem_ready = 1'b1;
    tick(); chk("ill_sticky2", ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,1));
    bus.zero = 1'b0;
    do_reset();

    // reset asserted while a store waits in MEMWRITE
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
    tick(); chk("rs_fetch",  ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b01, 3'b000,0));
    tick(); chk("rs_decode", ex(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b01, 3'b000,0));
    bus.mem_ready = 1'b0;
    tick(); chk("rs_memadr", ex(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000,0));
    tick(); chk("rs_memwrite", ex(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000,0));
    bus.mem_ready = 1'b1;
    do_reset();
    tick(); chk("rs_refetch", ex(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b01, 3'b000,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
